count_monitor: RTL and testbench
================================

# count_monitor

Synchronous checker and event extractor sitting directly downstream of the 3-bit enable/clear counter. Samples the counter's `count` bus with the same `en` and clear controls that drive it, verifies every transition is legal, emits wrap and match pulses, keeps a saturating wrap tally, and hands snapshots of {wrap tally, count} to the fault-tracking logic over a valid/ready handshake.

## Interface
- `CNT_W`, 3: width of monitored count.
- `WRAP_W`, 8: width of saturating wrap tally.
- `clk` input 1: rising-edge clock, same clock as the counter.
- `rst` input 1: synchronous, active-low reset of this block.
- `count` input CNT_W: counter output under observation.
- `en` input 1: counter enable, same signal the counter sees.
- `cnt_clr` input 1: counter's own active-high clear, same signal the counter sees.
- `match_val` input CNT_W: compare value; sampled every cycle.
- `err_clr` input 1: pulse; leaves FAULT.
- `snap_req` input 1: pulse; request snapshot.
- `snap_ready` input 1: consumer accepts snapshot.
- `snap_valid` output 1: snapshot held.
- `snap_data` output WRAP_W+CNT_W: {wrap_cnt, count} captured.
- `wrap_pulse` output 1: one-cycle, legal (2^CNT_W−1)→0 transition by increment.
- `match_pulse` output 1: one-cycle, count changed into `match_val`.
- `wrap_cnt` output WRAP_W: saturating wrap tally.
- `fault` output 1: high while in FAULT.
- `fault_code` output 2: 01 bad increment, 10 bad clear, 11 hold violation, 00 none.

## Operation
- Internal registers: `prev` (CNT_W), `en_d`, `clr_d` (previous-cycle `en`, `cnt_clr`), FSM state.
- States: INIT → TRACK → FAULT.
  - INIT: load `prev`←`count`, `en_d`, `clr_d`; no checks, no pulses; go TRACK next cycle.
  - TRACK: evaluate expected value each cycle, in priority order:
    - `clr_d`=1: expect 0; else fault_code 10.
    - `en_d`=1: expect (`prev`+1) mod 2^CNT_W; else fault_code 01.
    - otherwise: expect `prev` (only checked when hold check compiled in; else any change other than +1 mod wrap is code 01).
    - On mismatch: go FAULT, latch `fault_code`; no pulses that cycle.
  - FAULT: `fault`=1, `fault_code` held; `prev`/`en_d`/`clr_d` keep updating; no wrap/match pulses, `wrap_cnt` frozen. `err_clr` → INIT, `fault_code`←00.
- `wrap_pulse`: TRACK, legal increment, `prev`=all ones, `count`=0. Clear-to-0 from all ones is not a wrap.
- `wrap_cnt` increments on `wrap_pulse`, saturates at 2^WRAP_W−1, cleared only by `rst`.
- `match_pulse`: TRACK, legal transition, `count`≠`prev`, `count`=`match_val`.
- Snapshot: `snap_req` while `snap_valid`=0 captures {`wrap_cnt` after this cycle's update, `count`} and sets `snap_valid`. Data stable until `snap_valid`&`snap_ready`, which clears `snap_valid`. `snap_req` while `snap_valid`=1 is dropped, except in the accepting cycle, where the new capture wins and `snap_valid` stays 1. Snapshots allowed in any state.

## Timing
- `rst`=0 at rising edge: state INIT, all outputs 0, `prev`/`en_d`/`clr_d`/`wrap_cnt` 0; applies mid-operation, including pending snapshot (discarded).
- Counter output lags its `en`/`cnt_clr` by one cycle; monitor compares `count` at cycle n against controls from n−1.
- `wrap_pulse`, `match_pulse`, `fault` rise at the edge after the offending/qualifying `count` is sampled: one cycle latency, registered outputs.
- `snap_valid` rises one cycle after `snap_req`.
- `err_clr` and fault detection in the same cycle: `err_clr` wins, state INIT.

## Configuration
- `COUNT_MON_HOLD_CHECK_EN` defined: with `clr_d`=`en_d`=0, any change of `count` → FAULT code 11.
- Undefined: hold check absent; changes with controls low are checked only for being +1 mod 2^CNT_W (code 01 otherwise); code 11 never produced.

## Test plan
- Reset, `en`=1 for 16 cycles from count 0 → `wrap_pulse` twice (on samples 7→0), `wrap_cnt`=2, `fault`=0.
- `match_val`=5, count steps 4→5 → single `match_pulse` one cycle after 5 is sampled; held at 5 → no further pulse.
- Force `count` 3→6 with `en_d`=1 → `fault`=1, `fault_code`=01; `err_clr` → INIT then TRACK, code 00.
- `cnt_clr` at count 7 → count 0, no `wrap_pulse`, no fault; forced count 2 after clear → code 10.
- With `COUNT_MON_HOLD_CHECK_EN`, count 2→3 with `en`=0 → code 11; without macro → no fault.
- `snap_req` with `snap_ready`=0 for 4 cycles, second `snap_req` meanwhile → first data held, second dropped; `rst`=0 mid-hold → `snap_valid`=0.

Source files
------------

// File: rtl/count_monitor.sv
// count_monitor: checks transitions of a 3-bit enable/clear counter, emits wrap/match pulses,
// keeps a saturating wrap tally and serves {wrap_cnt, count} snapshots. Define COUNT_MON_HOLD_CHECK_EN to fault on changes while idle.
module count_monitor #(
    parameter int CNT_W  = 3,
    parameter int WRAP_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CNT_W-1:0]        count,
    input  logic                    en,
    input  logic                    cnt_clr,
    input  logic [CNT_W-1:0]        match_val,
    input  logic                    err_clr,
    input  logic                    snap_req,
    input  logic                    snap_ready,
    output logic                    snap_valid,
    output logic [WRAP_W+CNT_W-1:0] snap_data,
    output logic                    wrap_pulse,
    output logic                    match_pulse,
    output logic [WRAP_W-1:0]       wrap_cnt,
    output logic                    fault,
    output logic [1:0]              fault_code
);

    typedef enum logic [1:0] {INIT, TRACK, FAULT} state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  prev, inc;
    logic              en_d, clr_d;
    logic              ok, wrap_fire, match_fire;
    logic [1:0]        bad_code, code_nx;
    logic [WRAP_W-1:0] wrap_nx;

    assign inc = prev + {{(CNT_W-1){1'b0}}, 1'b1};

    // Expected value follows last cycle's controls, since the counter lags them by one cycle.
    always_comb begin
        ok       = 1'b1;
        bad_code = 2'b00;
        if (clr_d) begin
            ok       = (count == '0);
            bad_code = 2'b10;
        end else if (en_d) begin
            ok       = (count == inc);
            bad_code = 2'b01;
        end else begin
`ifdef COUNT_MON_HOLD_CHECK_EN
            ok       = (count == prev);
            bad_code = 2'b11;
`else
            ok       = (count == prev) || (count == inc);
            bad_code = 2'b01;
`endif
        end
    end

    always_comb begin
        state_nx   = state;
        code_nx    = fault_code;
        wrap_fire  = 1'b0;
        match_fire = 1'b0;
        case (state)
            INIT: begin
                state_nx = TRACK;
                code_nx  = 2'b00;
            end
            TRACK: begin
                if (!ok) begin
                    // err_clr takes priority over a fault detected in the same cycle
                    if (err_clr) begin
                        state_nx = INIT;
                        code_nx  = 2'b00;
                    end else begin
                        state_nx = FAULT;
                        code_nx  = bad_code;
                    end
                end else begin
                    wrap_fire  = !clr_d && (prev == '1) && (count == '0);
                    match_fire = (count != prev) && (count == match_val);
                end
            end
            FAULT: begin
                if (err_clr) begin
                    state_nx = INIT;
                    code_nx  = 2'b00;
                end
            end
            default: begin
                state_nx = INIT;
                code_nx  = 2'b00;
            end
        endcase
        wrap_nx = (wrap_fire && wrap_cnt != '1) ? wrap_cnt + 1'b1 : wrap_cnt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= INIT;
            prev        <= '0;
            en_d        <= 1'b0;
            clr_d       <= 1'b0;
            wrap_pulse  <= 1'b0;
            match_pulse <= 1'b0;
            wrap_cnt    <= '0;
            fault       <= 1'b0;
            fault_code  <= 2'b00;
        end else begin
            state       <= state_nx;
            prev        <= count;
            en_d        <= en;
            clr_d       <= cnt_clr;
            wrap_pulse  <= wrap_fire;
            match_pulse <= match_fire;
            wrap_cnt    <= wrap_nx;
            fault       <= (state_nx == FAULT);
            fault_code  <= code_nx;
        end
    end

    // A request in the accepting cycle replaces the outgoing snapshot back-to-back.
    always_ff @(posedge clk) begin
        if (!rst) begin
            snap_valid <= 1'b0;
            snap_data  <= '0;
        end else if (snap_req && (!snap_valid || snap_ready)) begin
            snap_valid <= 1'b1;
            snap_data  <= {wrap_nx, count};
        end else if (snap_valid && snap_ready) begin
            snap_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_count_monitor.sv
// Directed self-checking bench for count_monitor; the counter is modelled by driving count by hand.
module tb_count_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  count = '0;
    logic        en = 1'b0;
    logic        cnt_clr = 1'b0;
    logic [2:0]  match_val = 3'd5;
    logic        err_clr = 1'b0;
    logic        snap_req = 1'b0;
    logic        snap_ready = 1'b0;
    logic        snap_valid;
    logic [10:0] snap_data;
    logic        wrap_pulse;
    logic        match_pulse;
    logic [7:0]  wrap_cnt;
    logic        fault;
    logic [1:0]  fault_code;

    int passed = 0;
    int total  = 0;

    count_monitor #(.CNT_W(3), .WRAP_W(8)) dut (
        .clk(clk), .rst(rst), .count(count), .en(en), .cnt_clr(cnt_clr),
        .match_val(match_val), .err_clr(err_clr), .snap_req(snap_req),
        .snap_ready(snap_ready), .snap_valid(snap_valid), .snap_data(snap_data),
        .wrap_pulse(wrap_pulse), .match_pulse(match_pulse), .wrap_cnt(wrap_cnt),
        .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Drive one counter sample at the falling edge; return just after the sampling edge.
    task automatic cyc(input logic [2:0] c, input logic e, input logic cl);
        @(negedge clk);
        count   = c;
        en      = e;
        cnt_clr = cl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("rst_fault", fault, 0);
        chk("rst_code", fault_code, 0);
        chk("rst_wrapcnt", wrap_cnt, 0);
        chk("rst_snapv", snap_valid, 0);
        chk("rst_pulses", {wrap_pulse, match_pulse}, 0);

        rst = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            cyc(3'(k % 8), 1, 0);
            chk("run_wrap", wrap_pulse, (k == 8 || k == 16));
            chk("run_match", match_pulse, (k % 8 == 5 && k != 0));
        end
        chk("run_wrapcnt", wrap_cnt, 2);
        chk("run_fault", fault, 0);

        cyc(1, 1, 0); cyc(2, 1, 0); cyc(3, 1, 0); cyc(4, 1, 0);
        chk("m4_nomatch", match_pulse, 0);
        cyc(5, 0, 0);
        chk("m5_match", match_pulse, 1);
        cyc(5, 0, 0);
        chk("m5_hold1", match_pulse, 0);
        cyc(5, 0, 1);
        chk("m5_hold2", match_pulse, 0);

        cyc(0, 1, 0);
        chk("clr_ok", fault, 0);
        cyc(1, 1, 0); cyc(2, 1, 0); cyc(3, 1, 0);
        cyc(6, 0, 0);
        chk("inc_fault", fault, 1);
        chk("inc_code", fault_code, 2'b01);
        cyc(6, 0, 0);
        chk("inc_held", fault_code, 2'b01);
        err_clr = 1'b1;
        cyc(6, 0, 0);
        err_clr = 1'b0;
        chk("eclr_fault", fault, 0);
        chk("eclr_code", fault_code, 0);
        cyc(6, 1, 0);
        cyc(7, 0, 1);
        chk("to7_ok", fault, 0);
        cyc(0, 0, 0);
        chk("clr7_nowrap", wrap_pulse, 0);
        chk("clr7_nofault", fault, 0);
        cyc(0, 0, 1);
        cyc(2, 0, 0);
        chk("badclr_fault", fault, 1);
        chk("badclr_code", fault_code, 2'b10);
        chk("badclr_wcnt", wrap_cnt, 2);
        err_clr = 1'b1;
        cyc(2, 0, 0);
        err_clr = 1'b0;
        cyc(2, 0, 0);
        cyc(3, 0, 0);
`ifdef COUNT_MON_HOLD_CHECK_EN
        chk("hold_fault", fault, 1);
        chk("hold_code", fault_code, 2'b11);
`else
        chk("hold_fault", fault, 0);
        chk("hold_code", fault_code, 2'b00);
`endif
        err_clr = 1'b1;
        cyc(3, 0, 0);
        err_clr = 1'b0;
        cyc(3, 0, 0);
        err_clr = 1'b1;
        cyc(7, 1, 0);
        err_clr = 1'b0;
        chk("eclr_wins_f", fault, 0);
        chk("eclr_wins_c", fault_code, 0);
        cyc(7, 0, 0);
        cyc(7, 0, 0);
        chk("recover", fault, 0);

        snap_req = 1'b1;
        cyc(7, 1, 0);
        snap_req = 1'b0;
        chk("snap_v1", snap_valid, 1);
        chk("snap_d1", snap_data, {8'd2, 3'd7});
        cyc(0, 0, 0);
        chk("snap_wrap", wrap_pulse, 1);
        chk("snap_wcnt3", wrap_cnt, 3);
        snap_req = 1'b1;
        cyc(0, 0, 0);
        snap_req = 1'b0;
        chk("snap_drop", snap_data, {8'd2, 3'd7});
        cyc(0, 0, 0);
        chk("snap_held_v", snap_valid, 1);
        chk("snap_held_d", snap_data, {8'd2, 3'd7});
        snap_ready = 1'b1;
        snap_req   = 1'b1;
        cyc(0, 0, 0);
        snap_req = 1'b0;
        chk("snap_b2b_v", snap_valid, 1);
        chk("snap_b2b_d", snap_data, {8'd3, 3'd0});
        cyc(0, 0, 0);
        chk("snap_acc", snap_valid, 0);
        snap_ready = 1'b0;
        snap_req   = 1'b1;
        cyc(0, 0, 0);
        snap_req = 1'b0;
        chk("snap_v2", snap_valid, 1);
        rst = 1'b0;
        cyc(0, 0, 0);
        chk("mrst_snapv", snap_valid, 0);
        chk("mrst_wcnt", wrap_cnt, 0);
        chk("mrst_fault", fault, 0);

        rst = 1'b1;
        cyc(0, 1, 0);
        for (int k = 1; k <= 2048; k++) begin
            snap_req = (k == 8);
            cyc(3'(k % 8), 1, 0);
            if (k == 8) chk("snap_sameup", snap_data, {8'd1, 3'd0});
        end
        snap_req = 1'b0;
        chk("sat_wcnt", wrap_cnt, 255);
        chk("sat_pulse", wrap_pulse, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
